main_fsm: RTL



---
 rtl/riscv_ctrl_pkg.sv | 49 ++++
 rtl/instr_dec.sv | 20 ++
 rtl/main_fsm.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control encodings: FSM states, opcodes, ALUOp and mux selects.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Opcode -> immediate format select; purely combinational, reusable by other controllers.
module instr_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic [1:0]      imm_src
);

    // Immediate format lookup
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing.
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         alu_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               instr_done,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state_q;
    state_t state_d;
    logic   pc_update;
    logic   branch;
    logic   ir_write_raw;
    logic   reg_write_raw;
    logic   mem_write_raw;

    instr_dec u_instr_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d       = FETCH;
        alu_op        = ALUOP_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d       = FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src    = RES_READDATA;
                reg_write_raw = 1'b1;
                instr_done    = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                instr_done    = mem_ready;
                state_d       = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                instr_done    = 1'b1;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: begin
                // FETCH and unused encodings share the fetch decode; only FETCH proceeds
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                state_d      = (state_q == FETCH && mem_ready) ? DECODE : FETCH;
            end
        endcase
    end

    // Write enables are suppressed for the whole time reset is asserted
    always_comb begin
        ir_write  = rst_n & ir_write_raw;
        pc_write  = rst_n & (pc_update | (branch & zero));
        reg_write = rst_n & reg_write_raw;
        mem_write = rst_n & mem_write_raw;
        state_dbg = STATE_W'(state_q);
    end

endmodule
